// File: rtl/nonrestoring_divider.sv
// nonrestoring_divider
//   Sequential unsigned non-restoring divider. It uses A/Q/M shift registers and a
//   down-counter, and produces one quotient bit per clock. Operands are captured on a
//   start pulse. Quotient, remainder and the divide-by-zero flag are registered, and a
//   one-cycle done pulse marks each completion.
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        begin a division; only sampled while idle
//   dividend_in  unsigned dividend, captured with start
//   divisor_in   unsigned divisor, captured with start
//   busy         high whenever the controller is not idle
//   done         one-cycle completion pulse
//   quotient     result, held until the next completion
//   remainder    result, held until the next completion
//   div_by_zero  set when the last completed operation had a zero divisor
module nonrestoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [AW-1:0]    m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Datapath terms for one iteration and for the final remainder correction
  logic [AW-1:0] a_shift;
  logic [AW-1:0] a_step;
  logic [AW-1:0] a_corr;

  assign a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  // The sign of the partial remainder before the shift picks subtract or add
  assign a_step  = a_q[WIDTH] ? (a_shift + m_q) : (a_shift - m_q);
  // A negative final partial remainder is restored once by adding the divisor
  assign a_corr  = a_q[WIDTH] ? (a_q + m_q) : a_q;

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor_in != '0) begin
            a_d     = '0;
            q_d     = dividend_in;
            m_d     = {1'b0, divisor_in};
            cnt_d   = CW'(WIDTH);
            state_d = S_ITER;
          end else begin
            quo_d   = '1;
            rem_d   = dividend_in;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_ITER: begin
        a_d   = a_step;
        q_d   = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        a_d     = a_corr;
        quo_d   = q_q;
        rem_d   = a_corr[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered, so they follow the state being entered
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb_nonrestoring_divider
//   Directed checks of the 8-bit and 16-bit divider: results, latency, done pulse width,
//   divide-by-zero, ignored start while busy, async reset abort, and a back-to-back sweep.
module tb_nonrestoring_divider;

  logic        clk;
  logic        rst_n;

  logic        s8;
  logic [7:0]  dd8, dv8;
  logic        busy8, done8, dbz8;
  logic [7:0]  quo8, rem8;

  logic        s16;
  logic [15:0] dd16, dv16;
  logic        busy16, done16, dbz16;
  logic [15:0] quo16, rem16;

  int n_checks;
  int n_fail;

  nonrestoring_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8),
    .dividend_in(dd8), .divisor_in(dv8),
    .busy(busy8), .done(done8),
    .quotient(quo8), .remainder(rem8), .div_by_zero(dbz8)
  );

  nonrestoring_divider #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16),
    .dividend_in(dd16), .divisor_in(dv16),
    .busy(busy16), .done(done16),
    .quotient(quo16), .remainder(rem16), .div_by_zero(dbz16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Issue one division from an idle cycle (called #1 after an edge), wait for done,
  // check latency, results and that done lasts exactly one cycle.
  task automatic run_div(input string tag, input bit wide,
                         input logic [15:0] dd, input logic [15:0] dv,
                         input logic [15:0] exp_q, input logic [15:0] exp_r,
                         input bit exp_z, input int exp_lat);
    int n;
    if (wide) begin s16 = 1'b1; dd16 = dd; dv16 = dv; end
    else      begin s8  = 1'b1; dd8  = dd[7:0]; dv8 = dv[7:0]; end
    @(posedge clk); #1;
    s8 = 1'b0; s16 = 1'b0;
    n = 0;
    while (!(wide ? done16 : done8) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
    if (wide) begin
      check_eq({tag, "_q"}, 32'(quo16), 32'(exp_q));
      check_eq({tag, "_r"}, 32'(rem16), 32'(exp_r));
      check_eq({tag, "_z"}, 32'(dbz16), 32'(exp_z));
    end else begin
      check_eq({tag, "_q"}, 32'(quo8), 32'(exp_q[7:0]));
      check_eq({tag, "_r"}, 32'(rem8), 32'(exp_r[7:0]));
      check_eq({tag, "_z"}, 32'(dbz8), 32'(exp_z));
    end
    @(posedge clk); #1;
    check_eq({tag, "_done1cyc"}, 32'(wide ? done16 : done8), 32'd0);
    check_eq({tag, "_idle"},     32'(wide ? busy16 : busy8), 32'd0);
  endtask

  initial begin
    int n;
    int ndone;
    logic [15:0] rd, rv, eq, er;
    bit ez;

    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    s8 = 1'b0; dd8 = '0; dv8 = '0;
    s16 = 1'b0; dd16 = '0; dv16 = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy8), 32'd0);
    check_eq("rst_done", 32'(done8), 32'd0);
    check_eq("rst_q",    32'(quo8),  32'd0);
    check_eq("rst_r",    32'(rem8),  32'd0);
    check_eq("rst_z",    32'(dbz8),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic and boundary operands, back-to-back on the 8-bit unit
    run_div("d100_7", 1'b0, 16'd100, 16'd7, 16'd14,  16'd2, 1'b0, 9);
    run_div("d255_1", 1'b0, 16'd255, 16'd1, 16'd255, 16'd0, 1'b0, 9);
    run_div("d5_9",   1'b0, 16'd5,   16'd9, 16'd0,   16'd5, 1'b0, 9);
    run_div("d9_9",   1'b0, 16'd9,   16'd9, 16'd1,   16'd0, 1'b0, 9);
    run_div("d0_3",   1'b0, 16'd0,   16'd3, 16'd0,   16'd0, 1'b0, 9);
    run_div("d255_255", 1'b0, 16'd255, 16'd255, 16'd1, 16'd0, 1'b0, 9);
    run_div("d200_0", 1'b0, 16'd200, 16'd0, 16'hFF,  16'd200, 1'b1, 0);

    // Start pulse during ITER is ignored; operand changes after start have no effect
    s8 = 1'b1; dd8 = 8'd50; dv8 = 8'd3;
    @(posedge clk); #1;
    s8 = 1'b0;
    check_eq("hold_q_iter", 32'(quo8), 32'hFF);
    check_eq("hold_z_iter", 32'(dbz8), 32'd1);
    check_eq("busy_iter",   32'(busy8), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    s8 = 1'b1; dd8 = 8'd77; dv8 = 8'd5;
    @(posedge clk); #1;
    s8 = 1'b0; dd8 = 8'd0; dv8 = 8'd0;
    n = 3;
    while (!done8 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ign_lat", 32'(n),    32'd9);
    check_eq("ign_q",   32'(quo8), 32'd16);
    check_eq("ign_r",   32'(rem8), 32'd2);
    check_eq("ign_z",   32'(dbz8), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    check_eq("ign_no2nd", 32'(ndone), 32'd0);

    // Async reset mid-ITER clears outputs at once and aborts the operation
    s8 = 1'b1; dd8 = 8'd100; dv8 = 8'd7;
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy8), 32'd0);
    check_eq("arst_done", 32'(done8), 32'd0);
    check_eq("arst_q",    32'(quo8),  32'd0);
    check_eq("arst_r",    32'(rem8),  32'd0);
    check_eq("arst_z",    32'(dbz8),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    check_eq("arst_abort", 32'(ndone), 32'd0);
    run_div("d13_4", 1'b0, 16'd13, 16'd4, 16'd3, 16'd1, 1'b0, 9);

    // 16-bit unit
    run_div("w65535_255", 1'b1, 16'd65535, 16'd255, 16'd257, 16'd0, 1'b0, 17);
    run_div("w65535_1",   1'b1, 16'd65535, 16'd1,   16'd65535, 16'd0, 1'b0, 17);
    run_div("w1000_0",    1'b1, 16'd1000,  16'd0,   16'hFFFF, 16'd1000, 1'b1, 0);

    // Back-to-back random sweep against a reference model
    for (int i = 0; i < 40; i++) begin
      rd = 16'($urandom);
      case (i % 4)
        0:       rv = 16'($urandom_range(1, 15));
        1:       rv = 16'($urandom);
        2:       rv = (i % 8 == 2) ? 16'd0 : 16'($urandom_range(1, 255));
        default: rv = 16'($urandom_range(1, 65535));
      endcase
      if (rv == 16'd0) begin
        eq = 16'hFFFF; er = rd; ez = 1'b1;
      end else begin
        eq = rd / rv; er = rd % rv; ez = 1'b0;
      end
      run_div($sformatf("rnd%0d", i), 1'b1, rd, rv, eq, er, ez, (rv == 16'd0) ? 0 : 17);
      if (rv != 16'd0) begin
        check_eq($sformatf("rnd%0d_inv", i), 32'(quo16) * 32'(rv) + 32'(rem16), 32'(rd));
        check_eq($sformatf("rnd%0d_rlt", i), 32'(rem16 < rv), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
